led_counter_ctrl: RTL and testbench
===================================

Name: led_counter_ctrl

Overview:
- Run/pause/step/clear controller for the 8-bit LED counter datapath on the board.
- Takes four raw push-buttons, synchronises and debounces them, and sequences an 8-bit up/down counter through a prescaler.
- The counter value drives the LED bank directly.
- Sits between the board buttons and led[7:0].

Parameters:
- DIV, 65536: prescaler period in clk cycles per count step while running; must be >= 2.
- DEB_CYCLES, 250000: consecutive stable cycles required before a button level is accepted; must be >= 2.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- btn_run  input  1  raw button, asynchronous to clk; press toggles run/pause
- btn_step  input  1  raw button; press advances counter by one when not running
- btn_dir  input  1  raw button; press toggles count direction
- btn_clr  input  1  raw button; press returns to IDLE with counter 0
- led  output  8  current counter value
- state  output  2  00 IDLE, 01 RUN, 10 PAUSED
- dir_down  output  1  0 = count up, 1 = count down

Behaviour:
- Reset (async assert, registers released on clk) sets:
  - led = 0, state = IDLE, dir_down = 0
  - prescaler = 0
  - all synchroniser, debounce level and debounce counter registers = 0
- Input conditioning, per button:
  - 2-flop synchroniser (s1, s2).
  - Debounce counter increments each cycle s2 != deb_level; it clears when s2 == deb_level.
  - When the counter is at DEB_CYCLES-1 and s2 still differs, deb_level flips at the next edge and the counter clears.
  - Press event = deb_level & ~deb_prev, a one-cycle pulse; deb_prev is deb_level delayed one cycle.
  - Release produces no event.
  - Raw input high and stable from before edge 0: the controller action is visible after edge DEB_CYCLES+2.
  - A glitch shorter than DEB_CYCLES cycles produces no event.
- Event priority when several events fire in the same cycle: clr > run > step > dir.
  - Only the highest-priority event among clr/run/step acts.
  - dir is independent and also applies unless clr fires.
- FSM:
  - IDLE: run -> RUN. step -> led +/-1, stay IDLE. Prescaler held at 0.
  - RUN: prescaler counts 0..DIV-1; tick on prescaler == DIV-1, then prescaler wraps to 0. Each tick moves led +/-1. run -> PAUSED. step ignored.
  - PAUSED: prescaler holds its value, so phase is preserved on resume. run -> RUN. step -> led +/-1.
  - Any state: clr -> IDLE, led = 0, prescaler = 0. dir_down is NOT cleared by clr.
- Arithmetic:
  - led is 8 bits, modulo 256.
  - Up: 255 -> 0. Down: 0 -> 255.
- Simultaneous events:
  - dir toggle in the same cycle as a tick or step: the count move uses the old direction; the new direction applies from the next cycle.
  - run (RUN -> PAUSED) in the same cycle as a tick: the tick is applied and the prescaler wraps to 0.
- Reset mid-operation (any state, any debounce phase): immediate return to the reset values. Buttons held through reset deassertion produce a press event once debounced.

Test Plan (DIV=4, DEB_CYCLES=3):
- Reset, then press run (held 10 cycles): state = 01 after edge 5. led increments every 4 cycles: 1, 2, 3...
- RUN, 3 ticks (led = 3), press run: state = 10 and led holds 3 for 50 cycles. Press run again: next tick arrives after the remaining prescaler cycles, not a fresh 4.
- PAUSED, led = 0: press dir, then step: led = 255, dir_down = 1. Step again: led = 254. In RUN with led = 255 and dir up: next tick gives led = 0.
- 2-cycle glitch on btn_step: no change. Pulse held 3+ cycles: exactly one step. Holding for 100 cycles: still exactly one step.
- run, step and clr presses aligned in the same cycle while in RUN with led = 7 and dir_down = 1: state = 00, led = 0, dir_down = 1.
- Assert reset while in RUN with led = 42 and a debounce in progress: all outputs 0 and state IDLE within the same cycle. No spurious event after release unless a button is still held.

Source files
------------

// File: rtl/led_counter_ctrl.sv
// Run/pause/step/clear controller for the 8-bit LED counter.
// Four raw buttons are synchronised and debounced, then drive an up/down counter through a prescaler.
module led_counter_ctrl #(
   parameter int unsigned DIV        = 65536,
   parameter int unsigned DEB_CYCLES = 250000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_run,
   input  logic       btn_step,
   input  logic       btn_dir,
   input  logic       btn_clr,
   output logic [7:0] led,
   output logic [1:0] state,
   output logic       dir_down
);

   localparam int unsigned PW = $clog2(DIV);
   localparam int unsigned CW = $clog2(DEB_CYCLES);
   localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
   localparam logic [CW-1:0] DEB_MAX   = CW'(DEB_CYCLES - 1);

   localparam int unsigned BRun  = 0;
   localparam int unsigned BStep = 1;
   localparam int unsigned BDir  = 2;
   localparam int unsigned BClr  = 3;

   typedef enum logic [1:0] {
      StIdle   = 2'b00,
      StRun    = 2'b01,
      StPaused = 2'b10
   } state_e;

   logic [3:0]    raw;
   logic [3:0]    sync1_q;
   logic [3:0]    sync2_q;
   logic [3:0]    level_q;
   logic [3:0]    prev_q;
   logic [3:0]    press;
   logic [CW-1:0] deb_cnt_q [4];

   state_e        state_q;
   logic [7:0]    led_q;
   logic          dir_q;
   logic [PW-1:0] presc_q;
   logic          tick;
   logic [7:0]    led_move;

   assign raw = {btn_clr, btn_dir, btn_step, btn_run};

   // Level flips only after DEB_CYCLES consecutive cycles of disagreement.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         level_q <= '0;
         prev_q  <= '0;
         for (int i = 0; i < 4; i++) begin
            deb_cnt_q[i] <= '0;
         end
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
         prev_q  <= level_q;
         for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] == level_q[i]) begin
               deb_cnt_q[i] <= '0;
            end else if (deb_cnt_q[i] == DEB_MAX) begin
               deb_cnt_q[i] <= '0;
               level_q[i]   <= sync2_q[i];
            end else begin
               deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
            end
         end
      end
   end

   assign press    = level_q & ~prev_q;
   assign tick     = (state_q == StRun) && (presc_q == PRESC_MAX);
   // Moves always use the direction held before any same-cycle dir toggle.
   assign led_move = dir_q ? (led_q - 8'd1) : (led_q + 8'd1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         led_q   <= '0;
         dir_q   <= 1'b0;
         presc_q <= '0;
      end else if (press[BClr]) begin
         state_q <= StIdle;
         led_q   <= '0;
         presc_q <= '0;
      end else begin
         if (press[BDir]) begin
            dir_q <= ~dir_q;
         end
         case (state_q)
            StIdle: begin
               presc_q <= '0;
               if (press[BRun]) begin
                  state_q <= StRun;
               end else if (press[BStep]) begin
                  led_q <= led_move;
               end
            end
            StRun: begin
               presc_q <= tick ? '0 : presc_q + 1'b1;
               if (tick) begin
                  led_q <= led_move;
               end
               if (press[BRun]) begin
                  state_q <= StPaused;
               end
            end
            StPaused: begin
               // Prescaler holds so the tick phase survives the pause.
               if (press[BRun]) begin
                  state_q <= StRun;
               end else if (press[BStep]) begin
                  led_q <= led_move;
               end
            end
            default: begin
               state_q <= StIdle;
               presc_q <= '0;
            end
         endcase
      end
   end

   assign led      = led_q;
   assign state    = state_q;
   assign dir_down = dir_q;

endmodule

// File: tb/tb_led_counter_ctrl.sv
// Self-checking bench for led_counter_ctrl: directed scenarios plus random button activity,
// compared against a cycle-level behavioural model of the button/counter rules.
module tb_led_counter_ctrl;

   localparam int DIV = 4;
   localparam int DEB = 3;

   logic       clk;
   logic       reset;
   logic [3:0] btn;
   logic [7:0] led;
   logic [1:0] state;
   logic       dir_down;
   logic [10:0] obs;

   int n_vec;
   int n_err;

   // Behavioural model state
   int m_led, m_ph, m_st;
   bit m_dir;
   bit m_lvl [4];
   int m_run [4];
   bit m_press [4];
   bit m_d1 [4];
   bit m_d2 [4];

   led_counter_ctrl #(.DIV(DIV), .DEB_CYCLES(DEB)) dut (
      .clk      (clk),
      .reset    (reset),
      .btn_run  (btn[0]),
      .btn_step (btn[1]),
      .btn_dir  (btn[2]),
      .btn_clr  (btn[3]),
      .led      (led),
      .state    (state),
      .dir_down (dir_down)
   );

   assign obs = {dir_down, state, led};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [10:0] exp_vec();
      logic [1:0] st;
      logic [7:0] l;
      st = m_st[1:0];
      l  = m_led[7:0];
      return {m_dir, st, l};
   endfunction

   task automatic model_reset();
      m_led = 0; m_ph = 0; m_st = 0; m_dir = 0;
      for (int i = 0; i < 4; i++) begin
         m_lvl[i] = 0; m_run[i] = 0; m_press[i] = 0; m_d1[i] = 0; m_d2[i] = 0;
      end
   endtask

   // One clock edge of the spec's rules: act on presses accepted last cycle, then debounce.
   task automatic model_edge();
      int mv;
      bit tk;
      if (reset) begin
         model_reset();
         return;
      end
      if (m_press[3]) begin
         m_st = 0; m_led = 0; m_ph = 0;
      end else begin
         mv = m_dir ? 255 : 1;
         tk = (m_st == 1) && (m_ph == DIV - 1);
         if (m_press[2]) m_dir = !m_dir;
         if (m_st == 1) begin
            m_ph = (m_ph + 1) % DIV;
            if (tk) m_led = (m_led + mv) % 256;
            if (m_press[0]) m_st = 2;
         end else begin
            if (m_st == 0) m_ph = 0;
            if (m_press[0]) m_st = 1;
            else if (m_press[1]) m_led = (m_led + mv) % 256;
         end
      end
      for (int i = 0; i < 4; i++) begin
         m_press[i] = 0;
         if (m_d2[i] != m_lvl[i]) begin
            m_run[i]++;
            if (m_run[i] == DEB) begin
               m_lvl[i]   = m_d2[i];
               m_run[i]   = 0;
               m_press[i] = m_lvl[i];
            end
         end else begin
            m_run[i] = 0;
         end
         m_d2[i] = m_d1[i];
         m_d1[i] = btn[i];
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic press(input int idx, input int hold);
      btn[idx] = 1'b1;
      repeat (hold) cyc();
      btn[idx] = 1'b0;
      repeat (8) cyc();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      btn   = '0;
      model_reset();
      #1;
      n_vec++;
      if (obs !== 11'd0) begin
         n_err++; $display("FAIL reset_state: got %h want %h", obs, 11'd0);
      end
      @(negedge clk);
      cyc();
      reset = 1'b0;
      cyc();
      n_vec++;
      if (obs !== exp_vec()) begin
         n_err++; $display("FAIL reset_release: got %h want %h", obs, exp_vec());
      end
   endtask

   task automatic test_run();
      btn[0] = 1'b1;
      repeat (5) cyc();
      n_vec++;
      if (state !== 2'b00) begin
         n_err++; $display("FAIL run_early: state %b want 00", state);
      end
      cyc();
      n_vec++;
      if (state !== 2'b01) begin
         n_err++; $display("FAIL run_latency: state %b want 01", state);
      end
      repeat (4) cyc();
      n_vec++;
      if (led !== 8'd1) begin
         n_err++; $display("FAIL run_tick1: led %0d want 1", led);
      end
      repeat (4) cyc();
      n_vec++;
      if (led !== 8'd2) begin
         n_err++; $display("FAIL run_tick2: led %0d want 2", led);
      end
      btn[0] = 1'b0;
      for (int i = 0; i < 12; i++) begin
         cyc();
         n_vec++;
         if (obs !== exp_vec()) begin
            n_err++; $display("FAIL run_seq cyc %0d: got %h want %h", i, obs, exp_vec());
         end
      end
   endtask

   task automatic test_pause_resume();
      int p_led, p_ph, cnt;
      btn[0] = 1'b1;
      repeat (5) cyc();
      btn[0] = 1'b0;
      cyc();
      p_led = m_led;
      p_ph  = m_ph;
      for (int i = 0; i < 50; i++) begin
         cyc();
         n_vec++;
         if (state !== 2'b10 || led !== p_led[7:0]) begin
            n_err++; $display("FAIL pause_hold cyc %0d: st %b led %0d want 10 %0d", i, state, led, p_led);
         end
      end
      btn[0] = 1'b1;
      cnt = 0;
      while (state !== 2'b01 && cnt < 20) begin
         cyc(); cnt++;
      end
      btn[0] = 1'b0;
      cnt = 0;
      while (led === p_led[7:0] && cnt < 3 * DIV) begin
         cyc(); cnt++;
      end
      n_vec++;
      if (cnt != DIV - p_ph) begin
         n_err++; $display("FAIL resume_phase: %0d cycles want %0d", cnt, DIV - p_ph);
      end
      for (int i = 0; i < 10; i++) begin
         cyc();
         n_vec++;
         if (obs !== exp_vec()) begin
            n_err++; $display("FAIL resume_seq cyc %0d: got %h want %h", i, obs, exp_vec());
         end
      end
   endtask

   task automatic test_dir_wrap();
      int cnt;
      press(3, 4);
      n_vec++;
      if (state !== 2'b00 || led !== 8'd0) begin
         n_err++; $display("FAIL clr_idle: st %b led %0d want 00 0", state, led);
      end
      if (!m_dir) press(2, 4);
      press(1, 4);
      n_vec++;
      if (led !== 8'd255 || dir_down !== 1'b1) begin
         n_err++; $display("FAIL step_down_wrap: led %0d dir %b want 255 1", led, dir_down);
      end
      press(1, 4);
      n_vec++;
      if (led !== 8'd254) begin
         n_err++; $display("FAIL step_down2: led %0d want 254", led);
      end
      press(2, 4);
      press(1, 4);
      n_vec++;
      if (led !== 8'd255 || dir_down !== 1'b0) begin
         n_err++; $display("FAIL step_up: led %0d dir %b want 255 0", led, dir_down);
      end
      btn[0] = 1'b1;
      cnt = 0;
      while (state !== 2'b01 && cnt < 20) begin
         cyc(); cnt++;
      end
      cnt = 0;
      while (led === 8'd255 && cnt < 3 * DIV) begin
         cyc(); cnt++;
      end
      btn[0] = 1'b0;
      n_vec++;
      if (led !== 8'd0 || state !== 2'b01) begin
         n_err++; $display("FAIL run_up_wrap: led %0d st %b want 0 01", led, state);
      end
      repeat (8) cyc();
   endtask

   task automatic test_glitch();
      int base, mv;
      press(3, 4);
      base = m_led;
      mv   = m_dir ? 255 : 1;
      btn[1] = 1'b1;
      repeat (2) cyc();
      btn[1] = 1'b0;
      repeat (10) cyc();
      n_vec++;
      if (led !== base[7:0]) begin
         n_err++; $display("FAIL glitch: led %0d want %0d", led, base);
      end
      press(1, 3);
      base = (base + mv) % 256;
      n_vec++;
      if (led !== base[7:0]) begin
         n_err++; $display("FAIL pulse3: led %0d want %0d", led, base);
      end
      press(1, 100);
      base = (base + mv) % 256;
      n_vec++;
      if (led !== base[7:0]) begin
         n_err++; $display("FAIL hold100: led %0d want %0d", led, base);
      end
   endtask

   task automatic test_simultaneous();
      int cnt;
      press(3, 4);
      if (m_dir) press(2, 4);
      repeat (7) press(1, 4);
      press(2, 4);
      n_vec++;
      if (obs !== {1'b1, 2'b00, 8'd7}) begin
         n_err++; $display("FAIL pre_simul: got %h want %h", obs, {1'b1, 2'b00, 8'd7});
      end
      btn[0] = 1'b1;
      cnt = 0;
      while (state !== 2'b01 && cnt < 20) begin
         cyc(); cnt++;
      end
      btn[0] = 1'b0;
      repeat (6) cyc();
      btn = 4'b1011;
      repeat (4) cyc();
      btn = 4'b0000;
      repeat (8) cyc();
      n_vec++;
      if (obs !== {1'b1, 2'b00, 8'd0}) begin
         n_err++; $display("FAIL simul_clr: got %h want %h", obs, {1'b1, 2'b00, 8'd0});
      end
   endtask

   task automatic test_reset_mid();
      press(0, 4);
      repeat (10) cyc();
      btn[1] = 1'b1;
      repeat (2) cyc();
      reset = 1'b1;
      #1;
      model_reset();
      n_vec++;
      if (obs !== 11'd0) begin
         n_err++; $display("FAIL reset_mid: got %h want %h", obs, 11'd0);
      end
      btn[1] = 1'b0;
      @(negedge clk);
      repeat (2) cyc();
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         n_vec++;
         if (obs !== 11'd0 || obs !== exp_vec()) begin
            n_err++; $display("FAIL no_spurious cyc %0d: got %h want 0", i, obs);
         end
      end
      btn[0] = 1'b1;
      reset  = 1'b1;
      repeat (3) cyc();
      reset = 1'b0;
      repeat (10) cyc();
      n_vec++;
      if (state !== 2'b01 || obs !== exp_vec()) begin
         n_err++; $display("FAIL held_through_reset: got %h want %h", obs, exp_vec());
      end
      btn[0] = 1'b0;
      repeat (8) cyc();
   endtask

   task automatic test_random();
      for (int i = 0; i < 4000; i++) begin
         for (int b = 0; b < 3; b++) begin
            if ($urandom_range(0, 7) == 0) btn[b] = ~btn[b];
         end
         if ($urandom_range(0, 39) == 0) btn[3] = ~btn[3];
         cyc();
         n_vec++;
         if (obs !== exp_vec()) begin
            n_err++; $display("FAIL random cyc %0d: got %h want %h", i, obs, exp_vec());
         end
      end
      btn = '0;
      repeat (10) cyc();
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      test_reset();
      test_run();
      test_pause_resume();
      test_dir_wrap();
      test_glitch();
      test_simultaneous();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
